// File: rtl/massive_pwm_core.sv
// massive_pwm_core: multi-channel PWM with shadowed config applied on period wrap.
// Define MASSIVE_PWM_POLARITY_EN to add per-channel output polarity (cfg_polarity).
module massive_pwm_core #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16,
   parameter int PRE_W  = 16
) (
   input  logic                    ACLK,
   input  logic                    ARESETN,
   input  logic                    cfg_enable,
   input  logic [PRE_W-1:0]        cfg_prescale,
   input  logic [CNT_W-1:0]        cfg_period,
   input  logic [NUM_CH*CNT_W-1:0] cfg_duty,
   input  logic                    cfg_commit,
`ifdef MASSIVE_PWM_POLARITY_EN
   input  logic [NUM_CH-1:0]       cfg_polarity,
`endif
   output logic [NUM_CH-1:0]       pwm_out,
   output logic                    update_pending,
   output logic [CNT_W-1:0]        period_cnt,
   output logic                    period_done
);

   logic [PRE_W-1:0]        pre_cnt, pre_st, pre_sh;
   logic [CNT_W-1:0]        per_st, per_sh;
   logic [NUM_CH*CNT_W-1:0] duty_st, duty_sh;
   logic [NUM_CH-1:0]       raw, pol_sh;
   logic                    tick, wrap, load;

   assign tick = cfg_enable && (pre_cnt == pre_sh);
   assign wrap = tick && (period_cnt == per_sh);
   // staged values reach the shadows at a wrap, or at once while stopped
   assign load = update_pending && (wrap || !cfg_enable);

   always_comb begin
      raw = '0;
      for (int i = 0; i < NUM_CH; i++)
         raw[i] = cfg_enable && (period_cnt < duty_sh[i*CNT_W +: CNT_W]);
   end

`ifdef MASSIVE_PWM_POLARITY_EN
   logic [NUM_CH-1:0] pol_st;
   always_ff @(posedge ACLK or negedge ARESETN)
      if (!ARESETN) begin
         pol_st <= '0;
         pol_sh <= '0;
      end else begin
         if (cfg_commit) pol_st <= cfg_polarity;
         if (load) pol_sh <= pol_st;
      end
`else
   assign pol_sh = '0;
`endif

   always_ff @(posedge ACLK or negedge ARESETN)
      if (!ARESETN) begin
         pre_cnt        <= '0;
         period_cnt     <= '0;
         period_done    <= 1'b0;
         pwm_out        <= '0;
         update_pending <= 1'b0;
         pre_st         <= '0;
         per_st         <= '0;
         duty_st        <= '0;
         pre_sh         <= '0;
         per_sh         <= '0;
         duty_sh        <= '0;
      end else begin
         pre_cnt        <= (!cfg_enable || tick) ? '0 : pre_cnt + 1'b1;
         period_cnt     <= (!cfg_enable || wrap) ? '0 : tick ? period_cnt + 1'b1 : period_cnt;
         period_done    <= wrap;
         pwm_out        <= raw ^ pol_sh;
         // a commit in the load cycle keeps the new values pending for the next wrap
         update_pending <= cfg_commit || (update_pending && !load);
         if (cfg_commit) begin
            pre_st  <= cfg_prescale;
            per_st  <= cfg_period;
            duty_st <= cfg_duty;
         end
         if (load) begin
            pre_sh  <= pre_st;
            per_sh  <= per_st;
            duty_sh <= duty_st;
         end
      end

endmodule

// File: tb/tb_massive_pwm_core.sv
// tb_massive_pwm_core: directed checks of staging, shadow load, prescale, disable and reset.
module tb_massive_pwm_core;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic        cfg_enable = 1'b0;
   logic [15:0] cfg_prescale = '0;
   logic [15:0] cfg_period = '0;
   logic [63:0] cfg_duty = '0;
   logic        cfg_commit = 1'b0;
   logic [3:0]  pwm_out;
   logic        update_pending;
   logic [15:0] period_cnt;
   logic        period_done;
   int          checks = 0;
   int          failures = 0;
   int          hi[4];
   int          dn;

   massive_pwm_core dut (
      .ACLK(ACLK),
      .ARESETN(ARESETN),
      .cfg_enable(cfg_enable),
      .cfg_prescale(cfg_prescale),
      .cfg_period(cfg_period),
      .cfg_duty(cfg_duty),
      .cfg_commit(cfg_commit),
`ifdef MASSIVE_PWM_POLARITY_EN
      .cfg_polarity(4'b0000),
`endif
      .pwm_out(pwm_out),
      .update_pending(update_pending),
      .period_cnt(period_cnt),
      .period_done(period_done)
   );

   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic load_cfg(input logic [15:0] pre, input logic [15:0] per, input logic [63:0] duty);
      cfg_enable   = 1'b0;
      cfg_prescale = pre;
      cfg_period   = per;
      cfg_duty     = duty;
      cfg_commit   = 1'b1;
      @(negedge ACLK);
      cfg_commit = 1'b0;
      @(negedge ACLK);
   endtask

   initial begin
      repeat (3) @(negedge ACLK);
      chk("rst_pwm", pwm_out, 0);
      chk("rst_pend", update_pending, 0);
      chk("rst_cnt", period_cnt, 0);
      chk("rst_done", period_done, 0);
      ARESETN = 1'b1;
      // basic: period 10, duties 0/3/10/5
      cfg_prescale = 16'd0;
      cfg_period   = 16'd9;
      cfg_duty     = {16'd5, 16'd10, 16'd3, 16'd0};
      cfg_commit   = 1'b1;
      @(negedge ACLK);
      chk("stage_pend", update_pending, 1);
      cfg_commit = 1'b0;
      @(negedge ACLK);
      chk("dis_load_pend", update_pending, 0);
      cfg_enable = 1'b1;
      hi = '{0, 0, 0, 0};
      dn = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge ACLK);
         if (k == 0) begin
            chk("first_pwm", pwm_out, 4'b1110);
            chk("first_cnt", period_cnt, 1);
         end
         for (int c = 0; c < 4; c++) hi[c] += int'(pwm_out[c]);
         dn += int'(period_done);
      end
      chk("t1_hi0", hi[0], 0);
      chk("t1_hi1", hi[1], 6);
      chk("t1_hi2", hi[2], 20);
      chk("t1_hi3", hi[3], 10);
      chk("t1_done", dn, 2);
      // prescale 3, period 5 ticks
      load_cfg(16'd3, 16'd4, {16'd0, 16'd0, 16'd2, 16'd0});
      cfg_enable = 1'b1;
      hi = '{0, 0, 0, 0};
      dn = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge ACLK);
         if (k == 3) chk("t2_cnt_k3", period_cnt, 1);
         hi[1] += int'(pwm_out[1]);
         dn += int'(period_done);
      end
      chk("t2_hi1", hi[1], 16);
      chk("t2_done", dn, 2);
      // mid-period update and commit coincident with wrap
      load_cfg(16'd0, 16'd99, {48'd0, 16'd20});
      cfg_enable = 1'b1;
      hi = '{0, 0, 0, 0};
      for (int k = 0; k < 400; k++) begin
         @(negedge ACLK);
         hi[k/100] += int'(pwm_out[0]);
         if (k == 49) begin
            chk("t3_cnt50", period_cnt, 50);
            cfg_duty[15:0] = 16'd80;
            cfg_commit = 1'b1;
         end
         if (k == 50) begin
            chk("t3_pend_set", update_pending, 1);
            cfg_commit = 1'b0;
         end
         if (k == 98) chk("t3_pend_hold", update_pending, 1);
         if (k == 99) begin
            chk("t3_pend_clr", update_pending, 0);
            chk("t3_done", period_done, 1);
            chk("t3_no_runt", pwm_out[0], 0);
         end
         if (k == 149) begin
            cfg_duty[15:0] = 16'd30;
            cfg_commit = 1'b1;
         end
         if (k == 150) cfg_commit = 1'b0;
         if (k == 198) begin
            cfg_duty[15:0] = 16'd60;
            cfg_commit = 1'b1;
         end
         if (k == 199) begin
            chk("t4_pend_wrap", update_pending, 1);
            chk("t4_done", period_done, 1);
            cfg_commit = 1'b0;
         end
         if (k == 298) chk("t4_pend_hold", update_pending, 1);
         if (k == 299) chk("t4_pend_clr", update_pending, 0);
      end
      chk("t3_hi_p0", hi[0], 20);
      chk("t3_hi_p1", hi[1], 80);
      chk("t4_hi_p2", hi[2], 30);
      chk("t4_hi_p3", hi[3], 60);
      // disable at count 37 with a pending update
      load_cfg(16'd0, 16'd99, {48'd0, 16'd50});
      cfg_enable = 1'b1;
      for (int k = 0; k < 37; k++) begin
         @(negedge ACLK);
         if (k == 30) begin
            cfg_duty[15:0] = 16'd10;
            cfg_commit = 1'b1;
         end
         if (k == 31) cfg_commit = 1'b0;
      end
      chk("t5_cnt37", period_cnt, 37);
      chk("t5_pwm_run", pwm_out[0], 1);
      chk("t5_pend", update_pending, 1);
      cfg_enable = 1'b0;
      @(negedge ACLK);
      chk("t5_dis_pwm", pwm_out, 0);
      chk("t5_dis_cnt", period_cnt, 0);
      chk("t5_dis_pend", update_pending, 0);
      chk("t5_dis_done", period_done, 0);
      cfg_enable = 1'b1;
      for (int j = 0; j < 11; j++) begin
         @(negedge ACLK);
         if (j == 0) begin
            chk("t5_re_cnt", period_cnt, 1);
            chk("t5_re_pwm", pwm_out[0], 1);
         end
         if (j == 4) begin
            cfg_duty[15:0] = 16'd7;
            cfg_commit = 1'b1;
         end
         if (j == 5) begin
            cfg_commit = 1'b0;
            chk("t5_pend2", update_pending, 1);
         end
         if (j == 9) chk("t5_new_hi", pwm_out[0], 1);
         if (j == 10) chk("t5_new_lo", pwm_out[0], 0);
      end
      repeat (90) @(negedge ACLK);
      chk("t5_duty7_pwm", pwm_out[0], 1);
      chk("t5_duty7_pend", update_pending, 0);
      // reset mid-period with a staged update outstanding
      cfg_duty[15:0] = 16'd5;
      cfg_commit = 1'b1;
      @(negedge ACLK);
      cfg_commit = 1'b0;
      chk("t6_pend_pre", update_pending, 1);
      chk("t6_pwm_pre", pwm_out[0], 1);
      #2 ARESETN = 1'b0;
      #1;
      chk("t6_rst_pwm", pwm_out, 0);
      chk("t6_rst_cnt", period_cnt, 0);
      chk("t6_rst_pend", update_pending, 0);
      chk("t6_rst_done", period_done, 0);
      @(negedge ACLK);
      ARESETN = 1'b1;
      @(negedge ACLK);
      chk("t6_per0_cnt", period_cnt, 0);
      chk("t6_per0_done", period_done, 1);
      chk("t6_per0_pwm", pwm_out, 0);
      chk("t6_per0_pend", update_pending, 0);
      cfg_enable = 1'b0;
      @(negedge ACLK);
      chk("t6_dis_done", period_done, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
